role_select_ctrl: RTL and testbench

ROLE_SELECT_CTRL -- requirements
Module: role_select_ctrl

---
 rtl/role_select_ctrl_if.sv | 25 ++
 rtl/role_select_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_role_select_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/role_select_ctrl_if.sv
// UART byte channel between the role-selection controller and the serial link.
// The controller takes the master side: it offers tx bytes and consumes rx bytes.
interface role_select_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );
endinterface

// File: rtl/role_select_ctrl.sv
// Negotiates the local player role with the remote board over UART, runs the game,
// and reports the winner once either side has collided.
module role_select_ctrl #(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] CLAIM_P1       = 8'hA1,
    parameter logic [7:0] CLAIM_P2       = 8'hA2,
    parameter logic [7:0] ACK_BYTE       = 8'hAC,
    parameter logic [7:0] LOST_BYTE      = 8'hDE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_p1,
    input  logic                 btn_p2,
    input  logic                 btn_restart,
    input  logic                 player1_collision,
    input  logic                 player2_collision,
    role_select_ctrl_if.master   uart,
    output logic [1:0]           selected_player,
    output logic                 game_over,
    output logic [1:0]           winner
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ROLE_NONE = 2'b00;
    localparam logic [1:0] ROLE_P1   = 2'b01;
    localparam logic [1:0] ROLE_P2   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CLAIM,
        WAIT_ACK,
        SEND_ACK,
        PLAY,
        SEND_LOST,
        OVER
    } state_t;

    state_t           state, state_d;
    logic [1:0]       role, role_d;
    logic             tx_valid, tx_valid_d;
    logic [7:0]       tx_data, tx_data_d;
    logic [1:0]       sel_d;
    logic             over_d;
    logic [1:0]       win_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    logic       handshake;
    logic       local_col;
    logic       rx_lost;
    logic [7:0] own_claim, opp_claim;
    logic [1:0] local_win, remote_win;

    assign uart.tx_valid = tx_valid;
    assign uart.tx_data  = tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            role            <= ROLE_NONE;
            tx_valid        <= 1'b0;
            tx_data         <= 8'h00;
            selected_player <= 2'b00;
            game_over       <= 1'b0;
            winner          <= 2'b00;
            cnt             <= '0;
        end else begin
            state           <= state_d;
            role            <= role_d;
            tx_valid        <= tx_valid_d;
            tx_data         <= tx_data_d;
            selected_player <= sel_d;
            game_over       <= over_d;
            winner          <= win_d;
            cnt             <= cnt_d;
        end
    end

    // Role-relative views: which collision flag and claim byte belong to this board.
    always_comb begin
        handshake  = tx_valid && uart.tx_ready;
        rx_lost    = uart.rx_valid && (uart.rx_data == LOST_BYTE);
        local_col  = (role == ROLE_P1) ? player1_collision :
                     (role == ROLE_P2) ? player2_collision : 1'b0;
        own_claim  = (role == ROLE_P1) ? CLAIM_P1 : CLAIM_P2;
        opp_claim  = (role == ROLE_P1) ? CLAIM_P2 : CLAIM_P1;
        local_win  = (role == ROLE_P1) ? 2'b01 : 2'b10;
        remote_win = (role == ROLE_P1) ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d    = state;
        role_d     = role;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        sel_d      = selected_player;
        over_d     = game_over;
        win_d      = winner;
        cnt_d      = cnt;

        case (state)
            IDLE: begin
                if (uart.rx_valid && uart.rx_data == CLAIM_P1) begin
                    role_d     = ROLE_P2;
                    state_d    = SEND_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                end else if (uart.rx_valid && uart.rx_data == CLAIM_P2) begin
                    role_d     = ROLE_P1;
                    state_d    = SEND_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                end else if (btn_p1) begin
                    role_d     = ROLE_P1;
                    state_d    = SEND_CLAIM;
                    tx_valid_d = 1'b1;
                    tx_data_d  = CLAIM_P1;
                end else if (btn_p2) begin
                    role_d     = ROLE_P2;
                    state_d    = SEND_CLAIM;
                    tx_valid_d = 1'b1;
                    tx_data_d  = CLAIM_P2;
                end
            end
            SEND_CLAIM: begin
                if (handshake) begin
                    state_d    = WAIT_ACK;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    cnt_d      = '0;
                end
            end
            WAIT_ACK: begin
                // A crossed claim for the other role means both boards already agree.
                if (uart.rx_valid &&
                    (uart.rx_data == ACK_BYTE || uart.rx_data == opp_claim)) begin
                    state_d = PLAY;
                    sel_d   = role;
                end else if (uart.rx_valid && uart.rx_data == own_claim) begin
                    state_d = IDLE;
                    role_d  = ROLE_NONE;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    role_d  = ROLE_NONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            SEND_ACK: begin
                if (handshake) begin
                    state_d    = PLAY;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    sel_d      = role;
                end
            end
            PLAY: begin
                if (local_col) begin
                    state_d    = SEND_LOST;
                    tx_valid_d = 1'b1;
                    tx_data_d  = LOST_BYTE;
                    win_d      = rx_lost ? 2'b00 : remote_win;
                end else if (rx_lost) begin
                    state_d = OVER;
                    over_d  = 1'b1;
                    win_d   = local_win;
                end
            end
            SEND_LOST: begin
                if (handshake) begin
                    state_d    = OVER;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    over_d     = 1'b1;
                end
            end
            OVER: begin
                if (btn_restart) begin
                    state_d = IDLE;
                    role_d  = ROLE_NONE;
                    sel_d   = 2'b00;
                    over_d  = 1'b0;
                    win_d   = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_role_select_ctrl.sv
// Directed bench for role_select_ctrl: a table of one-cycle vectors for the main flows,
// then hand-written sequences for the timeout boundary and asynchronous reset.
module tb_role_select_ctrl;

    typedef struct packed {
        logic       b1;
        logic       b2;
        logic       rs;
        logic       rxv;
        logic [7:0] rxd;
        logic       txr;
        logic       c1;
        logic       c2;
        logic       txv;
        logic [7:0] txd;
        logic [1:0] sel;
        logic       over;
        logic [1:0] win;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_p1, btn_p2, btn_restart;
    logic       player1_collision, player2_collision;
    logic [1:0] selected_player;
    logic       game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    role_select_ctrl_if uart ();

    role_select_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .btn_p1            (btn_p1),
        .btn_p2            (btn_p2),
        .btn_restart       (btn_restart),
        .player1_collision (player1_collision),
        .player2_collision (player2_collision),
        .uart              (uart),
        .selected_player   (selected_player),
        .game_over         (game_over),
        .winner            (winner)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic b1, b2, rs, rxv, input logic [7:0] rxd,
                               input logic txr, c1, c2, txv, input logic [7:0] txd,
                               input logic [1:0] sel, input logic over, input logic [1:0] win);
        vec_t r;
        r = {b1, b2, rs, rxv, rxd, txr, c1, c2, txv, txd, sel, over, win};
        return r;
    endfunction

    task automatic drive(input vec_t t);
        btn_p1            = t.b1;
        btn_p2            = t.b2;
        btn_restart       = t.rs;
        uart.rx_valid     = t.rxv;
        uart.rx_data      = t.rxd;
        uart.tx_ready     = t.txr;
        player1_collision = t.c1;
        player2_collision = t.c2;
    endtask

    task automatic check_output(input string tag, input logic txv, input logic [7:0] txd,
                                input logic [1:0] sel, input logic over, input logic [1:0] win);
        logic [13:0] act, exp;
        act = {uart.tx_valid, uart.tx_data, selected_player, game_over, winner};
        exp = {txv, txd, sel, over, win};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got txv=%b txd=%h sel=%b over=%b win=%b, want txv=%b txd=%h sel=%b over=%b win=%b",
                     tag, act[13], act[12:5], act[4:3], act[2], act[1:0],
                     txv, txd, sel, over, win);
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled 1ns after the rising edge.
    task automatic apply_stimulus(input vec_t t, input string tag);
        @(negedge clk);
        drive(t);
        @(posedge clk);
        #1;
        check_output(tag, t.txv, t.txd, t.sel, t.over, t.win);
    endtask

    task automatic idle_cycles(input int n, input logic txr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(v(0,0,0,0,8'h00,txr,0,0, 0,8'h00,2'b00,0,2'b00));
        end
    endtask

    initial begin
        // Main flows, one row per clock.
        vecs.push_back(v(1,0,0,0,8'h00,1,0,0, 1,8'hA1,2'b00,0,2'b00)); // claim p1
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b00,0,2'b00)); // claim sent
        vecs.push_back(v(0,0,0,1,8'hAC,0,0,0, 0,8'h00,2'b01,0,2'b00)); // ack -> play
        vecs.push_back(v(0,0,0,0,8'h00,0,0,1, 0,8'h00,2'b01,0,2'b00)); // remote col ignored
        vecs.push_back(v(0,0,0,0,8'h00,1,1,0, 1,8'hDE,2'b01,0,2'b10)); // local col
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b01,1,2'b10)); // lost sent
        vecs.push_back(v(1,0,0,1,8'hA1,0,0,0, 0,8'h00,2'b01,1,2'b10)); // over ignores
        vecs.push_back(v(0,0,1,0,8'h00,0,0,0, 0,8'h00,2'b00,0,2'b00)); // restart
        vecs.push_back(v(1,0,0,1,8'hA1,0,0,0, 1,8'hAC,2'b00,0,2'b00)); // rx beats button
        vecs.push_back(v(0,0,0,0,8'h00,0,0,0, 1,8'hAC,2'b00,0,2'b00)); // ack held
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b11,0,2'b00)); // ack sent
        vecs.push_back(v(0,0,0,1,8'h55,0,0,0, 0,8'h00,2'b11,0,2'b00)); // junk byte
        vecs.push_back(v(0,0,0,0,8'h00,0,1,0, 0,8'h00,2'b11,0,2'b00)); // remote col ignored
        vecs.push_back(v(0,0,0,1,8'hDE,0,0,1, 1,8'hDE,2'b11,0,2'b00)); // draw
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b11,1,2'b00)); // draw over
        vecs.push_back(v(0,0,1,0,8'h00,0,0,0, 0,8'h00,2'b00,0,2'b00)); // restart
        vecs.push_back(v(1,1,0,0,8'h00,0,0,0, 1,8'hA1,2'b00,0,2'b00)); // both btns
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b00,0,2'b00)); // claim sent
        vecs.push_back(v(0,0,0,1,8'hA2,0,0,0, 0,8'h00,2'b01,0,2'b00)); // crossed claim
        vecs.push_back(v(0,0,0,1,8'hDE,0,0,0, 0,8'h00,2'b01,1,2'b01)); // remote lost
        vecs.push_back(v(0,0,1,0,8'h00,0,0,0, 0,8'h00,2'b00,0,2'b00)); // restart
        vecs.push_back(v(0,1,0,0,8'h00,0,0,0, 1,8'hA2,2'b00,0,2'b00)); // claim p2
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b00,0,2'b00)); // claim sent
        vecs.push_back(v(0,0,0,1,8'hA2,0,0,0, 0,8'h00,2'b00,0,2'b00)); // same claim -> idle
        vecs.push_back(v(0,0,0,1,8'hA1,0,0,0, 1,8'hAC,2'b00,0,2'b00)); // proves idle
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b11,0,2'b00)); // play p2
        vecs.push_back(v(0,0,0,0,8'h00,0,0,1, 1,8'hDE,2'b11,0,2'b01)); // p2 collides
        vecs.push_back(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b11,1,2'b01)); // over
        vecs.push_back(v(0,0,1,0,8'h00,0,0,0, 0,8'h00,2'b00,0,2'b00)); // restart

        drive(v(0,0,0,0,8'h00,0,0,0, 0,8'h00,2'b00,0,2'b00));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 0, 8'h00, 2'b00, 0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Still waiting after 15 idle cycles: a late ACK is accepted.
        apply_stimulus(v(1,0,0,0,8'h00,1,0,0, 1,8'hA1,2'b00,0,2'b00), "to15_claim");
        apply_stimulus(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b00,0,2'b00), "to15_sent");
        idle_cycles(15, 1'b0);
        apply_stimulus(v(0,0,0,1,8'hAC,0,0,0, 0,8'h00,2'b01,0,2'b00), "to15_late_ack");
        apply_stimulus(v(0,0,0,1,8'hDE,0,0,0, 0,8'h00,2'b01,1,2'b01), "to15_over");
        apply_stimulus(v(0,0,1,0,8'h00,0,0,0, 0,8'h00,2'b00,0,2'b00), "to15_restart");

        // After 16 idle cycles the claim has timed out: A1 now starts an ACK from IDLE.
        apply_stimulus(v(1,0,0,0,8'h00,1,0,0, 1,8'hA1,2'b00,0,2'b00), "to16_claim");
        apply_stimulus(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b00,0,2'b00), "to16_sent");
        idle_cycles(16, 1'b0);
        apply_stimulus(v(0,0,0,1,8'hA1,0,0,0, 1,8'hAC,2'b00,0,2'b00), "to16_idle");
        apply_stimulus(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b11,0,2'b00), "to16_play");
        apply_stimulus(v(0,0,0,1,8'hDE,0,0,0, 0,8'h00,2'b11,1,2'b10), "to16_over");
        apply_stimulus(v(0,0,1,0,8'h00,0,0,0, 0,8'h00,2'b00,0,2'b00), "to16_restart");

        // Asynchronous reset while a claim is stalled on tx_ready.
        apply_stimulus(v(1,0,0,0,8'h00,0,0,0, 1,8'hA1,2'b00,0,2'b00), "rst_claim");
        idle_cycles(5, 1'b0);
        @(posedge clk);
        #1;
        check_output("rst_claim_held", 1, 8'hA1, 2'b00, 0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_async", 0, 8'h00, 2'b00, 0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b00,0,2'b00));
        @(posedge clk);
        #1;
        check_output("rst_first_edge", 0, 8'h00, 2'b00, 0, 2'b00);
        apply_stimulus(v(0,1,0,0,8'h00,0,0,0, 1,8'hA2,2'b00,0,2'b00), "rst_resume");
        apply_stimulus(v(0,0,0,0,8'h00,1,0,0, 0,8'h00,2'b00,0,2'b00), "rst_sent");
        apply_stimulus(v(0,0,0,1,8'hAC,0,0,0, 0,8'h00,2'b11,0,2'b00), "rst_play");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
